// File: rtl/wb_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_result_stage
// Description : Writeback stage. MEM/WB pipeline register, N-way result
//               select, and load-lane extract with sign/zero extension.
//               Feeds the register-file write port and the WB forwarding
//               path.
// Ports       : clk, rst_n            clock, async active-low reset
//               in_valid, stall, flush  pipeline control
//               result_src, src_data    source select / packed source words
//               load_size, load_unsigned, addr_lsb   load shaping controls
//               rd_addr, reg_write      destination register info
//               wb_valid, wb_we, wb_rd, wb_result, wb_misalign  (registered)
// Revision    : 1.0  initial release
// ============================================================================
module wb_result_stage #(
    parameter  int WIDTH      = 32,
    parameter  int NUM_SRC    = 4,
    parameter  int MEM_SRC    = 1,
    parameter  int REG_ADDR_W = 5,
    localparam int SEL_W      = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [SEL_W-1:0]         result_src,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [1:0]               load_size,
    input  logic                     load_unsigned,
    input  logic [1:0]               addr_lsb,
    input  logic [REG_ADDR_W-1:0]    rd_addr,
    input  logic                     reg_write,
    output logic                     wb_valid,
    output logic                     wb_we,
    output logic [REG_ADDR_W-1:0]    wb_rd,
    output logic [WIDTH-1:0]         wb_result,
    output logic                     wb_misalign
);

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;

    logic [WIDTH-1:0]      w_sel;
    logic [31:0]           w_word;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [WIDTH-1:0]      w_ext;
    logic [WIDTH-1:0]      w_next_result;
    logic                  w_is_mem;
    logic                  w_misaligned;
    logic                  w_fill;

    logic                  r_valid;
    logic                  r_we;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [WIDTH-1:0]      r_result;
    logic                  r_misalign;

    // Source select; an index with no matching source yields zero.
    always_comb begin
        w_sel = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (int'(result_src) == k) begin
                w_sel = src_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_is_mem = (int'(result_src) == MEM_SRC);
    assign w_word   = w_sel[31:0];

    always_comb begin
        case (addr_lsb)
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
    end

    // Half lane is chosen by addr_lsb[1] alone; the odd-offset case is
    // reported through wb_misalign but still returns this lane's data.
    assign w_half = addr_lsb[1] ? w_word[31:16] : w_word[15:0];

    // Fill pattern first, then overwrite the low field. This avoids a
    // zero-width replication when WIDTH is exactly 32.
    always_comb begin
        w_fill = 1'b0;
        w_ext  = '0;
        case (load_size)
            c_SIZE_BYTE: begin
                w_fill     = ~load_unsigned & w_byte[7];
                w_ext      = {WIDTH{w_fill}};
                w_ext[7:0] = w_byte;
            end
            c_SIZE_HALF: begin
                w_fill      = ~load_unsigned & w_half[15];
                w_ext       = {WIDTH{w_fill}};
                w_ext[15:0] = w_half;
            end
            default: begin
                w_fill      = ~load_unsigned & w_word[31];
                w_ext       = {WIDTH{w_fill}};
                w_ext[31:0] = w_word;
            end
        endcase
    end

    assign w_next_result = w_is_mem ? w_ext : w_sel;

    // load_size 2'b1x is a word access: any nonzero offset is misaligned.
    assign w_misaligned = ((load_size == c_SIZE_HALF) && addr_lsb[0]) ||
                          (load_size[1] && (addr_lsb != 2'b00));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_we       <= 1'b0;
            r_rd       <= '0;
            r_result   <= '0;
            r_misalign <= 1'b0;
        end else if (flush) begin
            // Kill the entering instruction; data and address are left as-is.
            r_valid    <= 1'b0;
            r_we       <= 1'b0;
            r_misalign <= 1'b0;
        end else if (!stall) begin
            r_valid    <= in_valid;
            r_we       <= in_valid & reg_write & (rd_addr != '0);
            r_rd       <= rd_addr;
            r_result   <= w_next_result;
            r_misalign <= in_valid & w_is_mem & w_misaligned;
        end
    end

    assign wb_valid    = r_valid;
    assign wb_we       = r_we;
    assign wb_rd       = r_rd;
    assign wb_result   = r_result;
    assign wb_misalign = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_wb_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_result_stage
// Description : Self-checking bench for wb_result_stage. A table of directed
//               vectors covers select, load extraction and write-enable
//               rules; hand-written sequences cover stall, flush, reset and
//               an out-of-range select on a three-source instance.
// Revision    : 1.0  initial release
// ============================================================================
module tb_wb_result_stage;

    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, stall, flush;
    logic [1:0]        result_src;
    logic [4*WIDTH-1:0] src_data;
    logic [1:0]        load_size;
    logic              load_unsigned;
    logic [1:0]        addr_lsb;
    logic [4:0]        rd_addr;
    logic              reg_write;
    logic              wb_valid, wb_we, wb_misalign;
    logic [4:0]        wb_rd;
    logic [WIDTH-1:0]  wb_result;

    // Three-source instance; shares control inputs with the main DUT.
    logic [1:0]         result_src3;
    logic [3*WIDTH-1:0] src_data3;
    logic               wb_valid3, wb_we3, wb_misalign3;
    logic [4:0]         wb_rd3;
    logic [WIDTH-1:0]   wb_result3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_result_stage #(.WIDTH(32), .NUM_SRC(4), .MEM_SRC(1), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .result_src(result_src), .src_data(src_data), .load_size(load_size),
        .load_unsigned(load_unsigned), .addr_lsb(addr_lsb), .rd_addr(rd_addr),
        .reg_write(reg_write), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_result(wb_result), .wb_misalign(wb_misalign)
    );

    wb_result_stage #(.WIDTH(32), .NUM_SRC(3), .MEM_SRC(1), .REG_ADDR_W(5)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .result_src(result_src3), .src_data(src_data3), .load_size(load_size),
        .load_unsigned(load_unsigned), .addr_lsb(addr_lsb), .rd_addr(rd_addr),
        .reg_write(reg_write), .wb_valid(wb_valid3), .wb_we(wb_we3), .wb_rd(wb_rd3),
        .wb_result(wb_result3), .wb_misalign(wb_misalign3)
    );

    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] mem;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  lsb;
        logic [4:0]  rd;
        logic        rw;
        logic        valid;
        logic [31:0] exp_res;
        logic        exp_we;
        logic        exp_mis;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        result_src    = v.sel;
        src_data      = {32'hCAFE_BABE, 32'h0000_1004, v.mem, 32'h1234_5678};
        load_size     = v.size;
        load_unsigned = v.uns;
        addr_lsb      = v.lsb;
        rd_addr       = v.rd;
        reg_write     = v.rw;
        in_valid      = v.valid;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] res, input logic vld,
                           input logic we, input logic [4:0] rd, input logic mis);
        chk({tag, ".result"},   wb_result,          res);
        chk({tag, ".valid"},    32'(wb_valid),      32'(vld));
        chk({tag, ".we"},       32'(wb_we),         32'(we));
        chk({tag, ".rd"},       32'(wb_rd),         32'(rd));
        chk({tag, ".misalign"}, 32'(wb_misalign),   32'(mis));
    endtask

    initial begin
        //          sel   mem            size  uns  lsb  rd     rw  vld  exp_res        we   mis
        vecs[0]  = '{2'd0, 32'h80FF_7F01, 2'b00, 1'b0, 2'd0, 5'd5,  1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b0};
        vecs[1]  = '{2'd1, 32'h80FF_7F01, 2'b00, 1'b0, 2'd3, 5'd6,  1'b1, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b0};
        vecs[2]  = '{2'd1, 32'h80FF_7F01, 2'b00, 1'b0, 2'd1, 5'd6,  1'b1, 1'b1, 32'h0000_007F, 1'b1, 1'b0};
        vecs[3]  = '{2'd1, 32'h80FF_7F01, 2'b00, 1'b1, 2'd3, 5'd6,  1'b1, 1'b1, 32'h0000_0080, 1'b1, 1'b0};
        vecs[4]  = '{2'd1, 32'h80FF_7F01, 2'b00, 1'b0, 2'd0, 5'd6,  1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0};
        vecs[5]  = '{2'd1, 32'h8001_1234, 2'b01, 1'b0, 2'd2, 5'd7,  1'b1, 1'b1, 32'hFFFF_8001, 1'b1, 1'b0};
        vecs[6]  = '{2'd1, 32'h8001_1234, 2'b01, 1'b1, 2'd2, 5'd7,  1'b1, 1'b1, 32'h0000_8001, 1'b1, 1'b0};
        vecs[7]  = '{2'd1, 32'h8001_1234, 2'b01, 1'b1, 2'd1, 5'd7,  1'b1, 1'b1, 32'h0000_1234, 1'b1, 1'b1};
        vecs[8]  = '{2'd1, 32'h8001_1234, 2'b11, 1'b0, 2'd0, 5'd8,  1'b1, 1'b1, 32'h8001_1234, 1'b1, 1'b0};
        vecs[9]  = '{2'd1, 32'h8001_1234, 2'b10, 1'b1, 2'd2, 5'd8,  1'b1, 1'b1, 32'h8001_1234, 1'b1, 1'b1};
        vecs[10] = '{2'd2, 32'h8001_1234, 2'b00, 1'b0, 2'd3, 5'd1,  1'b1, 1'b1, 32'h0000_1004, 1'b1, 1'b0};
        vecs[11] = '{2'd3, 32'h8001_1234, 2'b01, 1'b0, 2'd1, 5'd31, 1'b1, 1'b1, 32'hCAFE_BABE, 1'b1, 1'b0};
        vecs[12] = '{2'd0, 32'h8001_1234, 2'b00, 1'b0, 2'd0, 5'd0,  1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0};
        vecs[13] = '{2'd1, 32'h8001_1234, 2'b01, 1'b1, 2'd1, 5'd7,  1'b1, 1'b0, 32'h0000_1234, 1'b0, 1'b0};
        vecs[14] = '{2'd0, 32'h8001_1234, 2'b00, 1'b0, 2'd0, 5'd9,  1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0};
        vecs[15] = '{2'd1, 32'h8001_1234, 2'b01, 1'b0, 2'd3, 5'd10, 1'b1, 1'b1, 32'hFFFF_8001, 1'b1, 1'b1};

        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        result_src3 = 2'd0; src_data3 = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        drive(vecs[0]);

        // Reset state.
        @(posedge clk); #1;
        chk_all("reset", 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk); rst_n = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk); drive(vecs[i]);
            @(posedge clk); #1;
            chk_all($sformatf("vec%0d", i), vecs[i].exp_res, vecs[i].valid,
                    vecs[i].exp_we, vecs[i].rd, vecs[i].exp_mis);
        end

        // Stall: load a misaligned half, then hold 3 cycles with changing inputs.
        @(negedge clk); drive(vecs[15]);
        @(posedge clk); #1;
        chk_all("pre_stall", 32'hFFFF_8001, 1'b1, 1'b1, 5'd10, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); stall = 1'b1; drive(vecs[c + 10]);
            @(posedge clk); #1;
            chk_all($sformatf("stall%0d", c), 32'hFFFF_8001, 1'b1, 1'b1, 5'd10, 1'b1);
        end
        // Flush beats stall: control bits clear, data and rd hold.
        @(negedge clk); flush = 1'b1; drive(vecs[0]);
        @(posedge clk); #1;
        chk_all("flush_stall", 32'hFFFF_8001, 1'b0, 1'b0, 5'd10, 1'b0);
        @(negedge clk); flush = 1'b0; stall = 1'b0; drive(vecs[1]);
        @(posedge clk); #1;
        chk_all("post_flush", 32'hFFFF_FF80, 1'b1, 1'b1, 5'd6, 1'b0);

        // Out-of-range select on the three-source instance.
        @(negedge clk); result_src3 = 2'd2;
        @(posedge clk); #1;
        chk("nsrc3.sel2", wb_result3, 32'h3333_3333);
        @(negedge clk); result_src3 = 2'd3;
        @(posedge clk); #1;
        chk("nsrc3.sel3", wb_result3, 32'h0);
        chk("nsrc3.we", 32'(wb_we3), 32'd1);

        // Async reset asserted mid-cycle while stalled.
        @(negedge clk); stall = 1'b1; drive(vecs[0]);
        @(posedge clk); #3; rst_n = 1'b0; #1;
        chk_all("async_rst", 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        chk("async_rst.nsrc3", wb_result3, 32'h0);
        @(negedge clk); stall = 1'b0; drive(vecs[11]);
        @(posedge clk); #1;
        chk_all("rst_held", 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk_all("rst_release", 32'hCAFE_BABE, 1'b1, 1'b1, 5'd31, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
